// File: rtl/tl_ul_channel_buffer.sv
// tl_ul_channel_buffer: registered TileLink-UL stage with one 2-entry FIFO on
// the A channel and one on the D channel. Optional per-source outstanding
// tracking and sticky protocol-error flags under TL_BUF_SRC_TRACK_EN.

// 2-entry circular FIFO; ready/valid are decoded from the count flops only,
// so no combinational path runs from one side to the other.
module tl_ul_fifo2 #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_bits,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_bits
);
   logic [1:0][W-1:0] mem;
   logic              wr_ptr, rd_ptr;
   logic [1:0]        count;
   logic              push, pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_bits  = mem[rd_ptr];

   // storage, pointers and occupancy; simultaneous push/pop keeps count
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_bits;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

module tl_ul_channel_buffer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SRC_W  = 2,
   parameter int SZ_W   = 2,
   parameter int A_W    = 3+3+SZ_W+SRC_W+ADDR_W+DATA_W/8+DATA_W+1,
   parameter int D_W    = 3+2+SZ_W+SRC_W+1+1+DATA_W+1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  in_a_valid,
   output logic                  in_a_ready,
   input  logic [A_W-1:0]        in_a_bits,
   output logic                  out_a_valid,
   input  logic                  out_a_ready,
   output logic [A_W-1:0]        out_a_bits,
   input  logic                  out_d_valid,
   output logic                  out_d_ready,
   input  logic [D_W-1:0]        out_d_bits,
   output logic                  in_d_valid,
   input  logic                  in_d_ready,
   output logic [D_W-1:0]        in_d_bits,
   output logic [2**SRC_W-1:0]   busy_o,
   output logic [1:0]            err_o
);
   tl_ul_fifo2 #(.W(A_W)) u_a_fifo (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_a_valid), .in_ready(in_a_ready), .in_bits(in_a_bits),
      .out_valid(out_a_valid), .out_ready(out_a_ready), .out_bits(out_a_bits)
   );

   tl_ul_fifo2 #(.W(D_W)) u_d_fifo (
      .clock(clock), .reset_n(reset_n),
      .in_valid(out_d_valid), .in_ready(out_d_ready), .in_bits(out_d_bits),
      .out_valid(in_d_valid), .out_ready(in_d_ready), .out_bits(in_d_bits)
   );

`ifdef TL_BUF_SRC_TRACK_EN
   // source field offsets within the packed beats (counted from the LSB)
   localparam int A_SRC_LSB = 1 + DATA_W + DATA_W/8 + ADDR_W;
   localparam int D_SRC_LSB = 1 + DATA_W + 1 + 1;

   logic [2**SRC_W-1:0] busy_q, busy_clr, busy_nxt;
   logic [1:0]          err_q, err_nxt;
   logic [SRC_W-1:0]    a_src, d_src;
   logic                a_fire, d_fire;

   // tracking taps the downstream side, where the monitor sees the link
   assign a_fire = out_a_valid & out_a_ready;
   assign d_fire = out_d_valid & out_d_ready;
   assign a_src  = out_a_bits[A_SRC_LSB +: SRC_W];
   assign d_src  = out_d_bits[D_SRC_LSB +: SRC_W];

   // D clear is applied before the A set, so a same-cycle retire+reissue
   // of one source leaves it busy without flagging reuse
   always_comb begin
      busy_clr = busy_q;
      err_nxt  = err_q;
      if (d_fire) begin
         if (!busy_clr[d_src]) err_nxt[1] = 1'b1;
         busy_clr[d_src] = 1'b0;
      end
      busy_nxt = busy_clr;
      if (a_fire) begin
         if (busy_clr[a_src]) err_nxt[0] = 1'b1;
         busy_nxt[a_src] = 1'b1;
      end
   end

   // outstanding bitmap and sticky error flags
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= '0;
         err_q  <= '0;
      end else begin
         busy_q <= busy_nxt;
         err_q  <= err_nxt;
      end
   end

   assign busy_o = busy_q;
   assign err_o  = err_q;
`else
   assign busy_o = '0;
   assign err_o  = '0;
`endif
endmodule
